// File: rtl/mem_port_arbiter_if.sv
// Memory port bundle: CPU and host request ports plus the shared memory bus.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_lock;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        output host_gnt, host_rvalid, host_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Host/CPU arbiter for the unified 256x16 memory with CPU starvation guard.
// Optional grant statistics counters are enabled by defining ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                Rst,
    mem_port_arbiter_if.slave   bus,
    output logic [15:0]         cpu_gnt_cnt,
    output logic [15:0]         host_gnt_cnt
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0]    wait_cnt;
    logic          cpu_gnt_c;
    logic          host_gnt_c;
    logic          cpu_rd_q;
    logic          host_rd_q;
    logic          cpu_rvalid_c;
    logic          host_rvalid_c;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] host_rdata_q;

    // Grant decision: lock, then starvation override, then host, then CPU.
    always_comb begin
        cpu_gnt_c  = 1'b0;
        host_gnt_c = 1'b0;
        if (!Rst) begin
            if (bus.host_lock) begin
                host_gnt_c = bus.host_req;
            end else if (bus.cpu_req && (wait_cnt >= MAX_W)) begin
                cpu_gnt_c = 1'b1;
            end else if (bus.host_req) begin
                host_gnt_c = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt_c = 1'b1;
            end
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_c;
    assign bus.host_gnt  = host_gnt_c;
    assign bus.cpu_stall = ~Rst & bus.cpu_req & ~cpu_gnt_c;

    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = 1'b0;
        if (host_gnt_c) begin
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
            bus.mem_we    = bus.host_we;
        end else if (cpu_gnt_c) begin
            bus.mem_we    = bus.cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst || cpu_gnt_c || !bus.cpu_req || bus.host_lock) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt < MAX_W) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            cpu_rd_q  <= 1'b0;
            host_rd_q <= 1'b0;
        end else begin
            cpu_rd_q  <= cpu_gnt_c & ~bus.cpu_we;
            host_rd_q <= host_gnt_c & ~bus.host_we;
        end
    end

    // A read granted just before reset must not surface during the reset cycle.
    assign cpu_rvalid_c  = cpu_rd_q & ~Rst;
    assign host_rvalid_c = host_rd_q & ~Rst;

    always_ff @(posedge clk) begin
        if (Rst) begin
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            if (cpu_rvalid_c) begin
                cpu_rdata_q <= bus.mem_rdata;
            end
            if (host_rvalid_c) begin
                host_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_rvalid  = cpu_rvalid_c;
    assign bus.host_rvalid = host_rvalid_c;
    assign bus.cpu_rdata   = cpu_rvalid_c  ? bus.mem_rdata : cpu_rdata_q;
    assign bus.host_rdata  = host_rvalid_c ? bus.mem_rdata : host_rdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] cpu_cnt_q;
    logic [15:0] host_cnt_q;

    always_ff @(posedge clk) begin
        if (Rst) begin
            cpu_cnt_q  <= '0;
            host_cnt_q <= '0;
        end else begin
            if (cpu_gnt_c && (cpu_cnt_q != 16'hFFFF)) begin
                cpu_cnt_q <= cpu_cnt_q + 16'd1;
            end
            if (host_gnt_c && (host_cnt_q != 16'hFFFF)) begin
                host_cnt_q <= host_cnt_q + 16'd1;
            end
        end
    end

    assign cpu_gnt_cnt  = cpu_cnt_q;
    assign host_gnt_cnt = host_cnt_q;
`else
    assign cpu_gnt_cnt  = 16'd0;
    assign host_gnt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic clk;
    logic rst;
    logic [15:0] cpu_gnt_cnt;
    logic [15:0] host_gnt_cnt;

    mem_port_arbiter_if #(.AW(8), .DW(16)) bus ();

    mem_port_arbiter #(.AW(8), .DW(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .Rst          (rst),
        .bus          (bus),
        .cpu_gnt_cnt  (cpu_gnt_cnt),
        .host_gnt_cnt (host_gnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory, 1-cycle read latency.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int vec = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [15:0] shadow [256];
    int          denied;
    bit          c_pend, h_pend;
    logic [15:0] c_pdata, h_pdata, c_hold, h_hold;
    int          c_cnt, h_cnt;
    bit          eg_c, eg_h;

    task automatic set(input bit r, input bit cr, input bit cw, input logic [7:0] ca,
                       input logic [15:0] cd, input bit hr, input bit hw,
                       input logic [7:0] ha, input logic [15:0] hd, input bit lk);
        rst = r;
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.host_req = hr; bus.host_we = hw; bus.host_addr = ha; bus.host_wdata = hd;
        bus.host_lock = lk;
    endtask

    task automatic compute();
        eg_c = 0;
        eg_h = 0;
        if (!rst) begin
            if (bus.host_lock) eg_h = bus.host_req;
            else if (bus.cpu_req && denied >= MAX_WAIT) eg_c = 1;
            else if (bus.host_req) eg_h = 1;
            else if (bus.cpu_req) eg_c = 1;
        end
    endtask

    task automatic check();
        logic [15:0] e_addr, e_wd;
        bit e_we;
        @(negedge clk);
        compute();
        e_addr = eg_h ? {8'h00, bus.host_addr} : {8'h00, bus.cpu_addr};
        e_wd   = eg_h ? bus.host_wdata : bus.cpu_wdata;
        e_we   = (eg_c && bus.cpu_we) || (eg_h && bus.host_we);
        chk("cpu_gnt", bus.cpu_gnt, eg_c);
        chk("host_gnt", bus.host_gnt, eg_h);
        chk("cpu_stall", bus.cpu_stall, !rst && bus.cpu_req && !eg_c);
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wd);
        chk("cpu_rvalid", bus.cpu_rvalid, c_pend && !rst);
        chk("host_rvalid", bus.host_rvalid, h_pend && !rst);
        chk("cpu_rdata", bus.cpu_rdata, (c_pend && !rst) ? c_pdata : c_hold);
        chk("host_rdata", bus.host_rdata, (h_pend && !rst) ? h_pdata : h_hold);
    endtask

    task automatic adv();
        compute();
        if (rst) begin
            denied = 0; c_pend = 0; h_pend = 0;
            c_hold = 0; h_hold = 0; c_cnt = 0; h_cnt = 0;
        end else begin
            if (c_pend) c_hold = c_pdata;
            if (h_pend) h_hold = h_pdata;
            if (eg_c || !bus.cpu_req || bus.host_lock) denied = 0;
            else if (denied < MAX_WAIT) denied++;
            c_pend = eg_c && !bus.cpu_we;
            h_pend = eg_h && !bus.host_we;
            c_pdata = shadow[bus.cpu_addr];
            h_pdata = shadow[bus.host_addr];
            if (eg_c && bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
            if (eg_h && bus.host_we) shadow[bus.host_addr] = bus.host_wdata;
            if (eg_c && c_cnt < 65535) c_cnt++;
            if (eg_h && h_cnt < 65535) h_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        check();
        adv();
    endtask

    typedef struct {
        bit rst, creq, cwe, hreq, hwe, lock;
        bit e_cg, e_hg, e_stall;
    } row_t;

    row_t tbl[$];

    initial begin
        bit lk;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'(i * 16'h0101) ^ 16'h5a5a;
            shadow[i] = mem[i];
        end
        mem[0] = 16'h1180;
        shadow[0] = 16'h1180;
        denied = 0; c_pend = 0; h_pend = 0;
        c_pdata = 0; h_pdata = 0; c_hold = 0; h_hold = 0;
        c_cnt = 0; h_cnt = 0;

        // Contention and lock table: rst, creq, cwe, hreq, hwe, lock, cg, hg, stall
        tbl.push_back('{1,1,0,1,0,0, 0,0,0});
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) tbl.push_back('{0,1,0,1,0,0, 0,1,1});
            tbl.push_back('{0,1,0,1,0,0, 1,0,0});
        end
        tbl.push_back('{0,1,0,1,0,1, 0,1,1});
        tbl.push_back('{0,1,0,1,0,1, 0,1,1});
        tbl.push_back('{0,1,0,1,0,0, 0,1,1});
        tbl.push_back('{0,1,0,0,0,1, 0,0,1});
        tbl.push_back('{0,1,0,0,0,0, 1,0,0});

        // Reset; first cycle is not checked because registers start unknown.
        set(1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        adv();
        cyc();

        // Host-only program load and readback.
        set(0, 0, 0, 8'h00, 16'h0, 1, 1, 8'h80, 16'h0001, 0);
        cyc();
        set(0, 0, 0, 8'h00, 16'h0, 1, 1, 8'h81, 16'h0021, 0);
        cyc();
        set(0, 0, 0, 8'h00, 16'h0, 1, 0, 8'h81, 16'h0, 0);
        cyc();
        set(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        check();
        chk("load_host_rvalid", bus.host_rvalid, 1);
        chk("load_host_rdata", bus.host_rdata, 16'h0021);
        chk("load_cpu_rvalid", bus.cpu_rvalid, 0);
        adv();

        // CPU-only read of address 0.
        set(0, 1, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        check();
        chk("cpurd_gnt", bus.cpu_gnt, 1);
        chk("cpurd_stall", bus.cpu_stall, 0);
        adv();
        set(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        check();
        chk("cpurd_rvalid", bus.cpu_rvalid, 1);
        chk("cpurd_rdata", bus.cpu_rdata, 16'h1180);
        adv();

        // Directed table.
        foreach (tbl[i]) begin
            set(tbl[i].rst, tbl[i].creq, tbl[i].cwe, 8'h10, 16'h0,
                tbl[i].hreq, tbl[i].hwe, 8'h20, 16'h0, tbl[i].lock);
            check();
            chk($sformatf("tbl%0d_cpu_gnt", i), bus.cpu_gnt, tbl[i].e_cg);
            chk($sformatf("tbl%0d_host_gnt", i), bus.host_gnt, tbl[i].e_hg);
            chk($sformatf("tbl%0d_stall", i), bus.cpu_stall, tbl[i].e_stall);
            adv();
        end

        // CPU read in flight when lock rises still returns; then 20 locked cycles.
        set(0, 1, 0, 8'h05, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        cyc();
        for (int i = 0; i < 20; i++) begin
            set(0, 1, 0, 8'h06, 16'h0, 1, 0, 8'(8'h30 + i), 16'h0, 1);
            check();
            if (i == 0) chk("lock_inflight_rvalid", bus.cpu_rvalid, 1);
            chk("lock_cpu_gnt", bus.cpu_gnt, 0);
            adv();
        end
        set(0, 1, 0, 8'h06, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        check();
        chk("unlock_cpu_gnt", bus.cpu_gnt, 1);
        adv();

        // Reset the cycle after a CPU read grant.
        set(0, 1, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        cyc();
        set(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        cyc();
        set(0, 1, 0, 8'h07, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        cyc();
        set(1, 1, 1, 8'h07, 16'hbeef, 1, 1, 8'h08, 16'hcafe, 0);
        check();
        chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_gnts", {bus.cpu_gnt, bus.host_gnt}, 0);
        adv();
        set(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        check();
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_cpu_rvalid2", bus.cpu_rvalid, 0);
        adv();

        // Randomized traffic.
        lk = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) lk = ~lk;
            set($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, 8'($urandom), 16'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 0,
                8'($urandom), 16'($urandom), lk);
            cyc();
        end

        // Grant statistics: 3 host writes plus 2 CPU reads after reset.
        set(1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            set(0, 0, 0, 8'h00, 16'h0, 1, 1, 8'(8'h90 + i), 16'(i), 0);
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            set(0, 1, 0, 8'(8'h90 + i), 16'h0, 0, 0, 8'h00, 16'h0, 0);
            cyc();
        end
        set(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
        check();
`ifdef ARB_STATS_EN
        chk("host_gnt_cnt", host_gnt_cnt, 3);
        chk("cpu_gnt_cnt", cpu_gnt_cnt, 2);
        chk("host_gnt_cnt_model", host_gnt_cnt, 32'(h_cnt));
`else
        chk("host_gnt_cnt", host_gnt_cnt, 0);
        chk("cpu_gnt_cnt", cpu_gnt_cnt, 0);
`endif
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
